// File: rtl/led_btn_ctrl.sv
// ---------------------------------------------------------------------------
// led_btn_ctrl
//   Two raw push-buttons (mode, action) are synchronised, debounced and turned
//   into single-cycle press events. A four-mode controller drives an N_LED-wide
//   LED bank: TOGGLE (invert bit 0), COUNT (binary increment), SHIFT (rotate
//   left) and BLINK (free-running inversion of the whole bank).
//
// Ports
//   clk        system clock (1 MHz nominal), single domain
//   n_reset    asynchronous active-low reset
//   btn_mode   raw mode button, active-high, asynchronous to clk
//   btn_act    raw action button, active-high, asynchronous to clk
//   led        LED drive, registered
//   mode       current mode (0 TOGGLE, 1 COUNT, 2 SHIFT, 3 BLINK), registered
//   act_pulse  one-cycle strobe for every accepted action press, registered
// ---------------------------------------------------------------------------

// Button conditioning: 2-FF synchroniser, counter debouncer, rising-edge press.
//   clk, n_reset  clock / asynchronous active-low reset
//   raw           raw button level
//   press         one-cycle, combinational strobe on a debounced rising edge
module led_btn_cond #(
  parameter int DEB_CYCLES = 20000
) (
  input  logic clk,
  input  logic n_reset,
  input  logic raw,
  output logic press
);

  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic          sync0;
  logic          s;
  logic          d;
  logic          d_prev;
  logic [CW-1:0] cnt;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours; blocking here would collapse the
  // synchroniser chain into a single stage.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      sync0  <= 1'b0;
      s      <= 1'b0;
      d      <= 1'b0;
      d_prev <= 1'b0;
      cnt    <= '0;
    end else begin
      sync0  <= raw;
      s      <= sync0;
      d_prev <= d;
      if (s == d) begin
        // Any return to the accepted level abandons the candidate change.
        cnt <= '0;
      end else if (cnt == CW'(DEB_CYCLES - 1)) begin
        // This edge is the DEB_CYCLES-th consecutive differing cycle.
        d   <= s;
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign press = d & ~d_prev;

endmodule

module led_btn_ctrl #(
  parameter int N_LED      = 4,
  parameter int DEB_CYCLES = 20000,
  parameter int BLINK_DIV  = 250000
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             btn_mode,
  input  logic             btn_act,
  output logic [N_LED-1:0] led,
  output logic [1:0]       mode,
  output logic             act_pulse
);

  localparam int BW = $clog2(BLINK_DIV);

  typedef enum logic [1:0] {
    TOGGLE = 2'd0,
    COUNT  = 2'd1,
    SHIFT  = 2'd2,
    BLINK  = 2'd3
  } mode_t;

  logic mode_press;
  logic act_press;

  led_btn_cond #(.DEB_CYCLES(DEB_CYCLES)) u_cond_mode (
    .clk     (clk),
    .n_reset (n_reset),
    .raw     (btn_mode),
    .press   (mode_press)
  );

  led_btn_cond #(.DEB_CYCLES(DEB_CYCLES)) u_cond_act (
    .clk     (clk),
    .n_reset (n_reset),
    .raw     (btn_act),
    .press   (act_press)
  );

  mode_t            mode_q,  mode_d;
  logic [N_LED-1:0] led_q,   led_d;
  logic             run_q,   run_d;
  logic [BW-1:0]    bcnt_q,  bcnt_d;
  logic             pulse_q, pulse_d;

  // LED value loaded when a mode is entered.
  function automatic logic [N_LED-1:0] entry_led(input mode_t m);
    logic [N_LED-1:0] v;
    v = '1;
    case (m)
      TOGGLE: v = '1;
      COUNT:  v = '0;
      SHIFT:  v = N_LED'(1);
      BLINK:  v = '1;
      default: v = '1;
    endcase
    return v;
  endfunction

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      mode_q  <= TOGGLE;
      led_q   <= '1;
      run_q   <= 1'b0;
      bcnt_q  <= '0;
      pulse_q <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      led_q   <= led_d;
      run_q   <= run_d;
      bcnt_q  <= bcnt_d;
      pulse_q <= pulse_d;
    end
  end

  // Priority: mode press, then action press, then blink timing. A mode press
  // swallows a coincident action press; an action press in BLINK overrides the
  // terminal-count inversion on the same edge.
  always_comb begin
    // NOTE: every output of this block gets a hold/default value first, so no
    // path through the branches below leaves a signal unassigned (no latches).
    mode_d  = mode_q;
    led_d   = led_q;
    run_d   = run_q;
    bcnt_d  = bcnt_q;
    pulse_d = 1'b0;

    if (mode_press) begin
      case (mode_q)
        TOGGLE:  mode_d = COUNT;
        COUNT:   mode_d = SHIFT;
        SHIFT:   mode_d = BLINK;
        BLINK:   mode_d = TOGGLE;
        default: mode_d = TOGGLE;
      endcase
      led_d  = entry_led(mode_d);
      run_d  = 1'b0;
      bcnt_d = '0;
    end else if (act_press) begin
      pulse_d = 1'b1;
      case (mode_q)
        TOGGLE: led_d[0] = ~led_q[0];
        COUNT:  led_d    = led_q + N_LED'(1);
        SHIFT:  led_d    = {led_q[N_LED-2:0], led_q[N_LED-1]};
        BLINK: begin
          run_d  = ~run_q;
          bcnt_d = '0;
        end
        default: led_d = led_q;
      endcase
    end else if (mode_q == BLINK && run_q) begin
      if (bcnt_q == BW'(BLINK_DIV - 1)) begin
        led_d  = ~led_q;
        bcnt_d = '0;
      end else begin
        bcnt_d = bcnt_q + BW'(1);
      end
    end
  end

  assign led       = led_q;
  assign mode      = mode_q;
  assign act_pulse = pulse_q;

endmodule

// File: tb/tb_led_btn_ctrl.sv
// ---------------------------------------------------------------------------
// tb_led_btn_ctrl
//   Directed bench for led_btn_ctrl with DEB_CYCLES = 4 and BLINK_DIV = 8.
//   Each expected action press pushes the expected {led, mode} into a queue;
//   a negedge monitor pops and compares whenever act_pulse is seen high.
// ---------------------------------------------------------------------------
module tb_led_btn_ctrl;

  localparam int N    = 4;
  localparam int DEB  = 4;
  localparam int BDIV = 8;

  logic         clk       = 1'b0;
  logic         n_reset   = 1'b0;
  logic         btn_mode  = 1'b0;
  logic         btn_act   = 1'b0;
  logic [N-1:0] led;
  logic [1:0]   mode;
  logic         act_pulse;

  led_btn_ctrl #(
    .N_LED      (N),
    .DEB_CYCLES (DEB),
    .BLINK_DIV  (BDIV)
  ) dut (
    .clk       (clk),
    .n_reset   (n_reset),
    .btn_mode  (btn_mode),
    .btn_act   (btn_act),
    .led       (led),
    .mode      (mode),
    .act_pulse (act_pulse)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] led;
    logic [1:0]   mode;
  } exp_t;

  exp_t sb[$];

  int total     = 0;
  int bad       = 0;
  int pulse_cnt = 0;

  logic [N-1:0] led_m;
  logic [1:0]   mode_m;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every act_pulse must match a queued expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (n_reset === 1'b1 && act_pulse !== 1'b0) begin
      pulse_cnt++;
      if (sb.size() == 0) begin
        check("unexpected_act_pulse", 32'(act_pulse), 32'd0);
      end else begin
        e = sb.pop_front();
        check("sb_led", 32'(led), 32'(e.led));
        check("sb_mode", 32'(mode), 32'(e.mode));
      end
    end
  end

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [N-1:0] entry_of(input logic [1:0] m);
    logic [N-1:0] v;
    v = (m == 2'd1) ? 4'b0000 : (m == 2'd2) ? 4'b0001 : 4'b1111;
    return v;
  endfunction

  function automatic void push_exp();
    exp_t e;
    e.led  = led_m;
    e.mode = mode_m;
    sb.push_back(e);
  endfunction

  task automatic do_reset();
    n_reset = 1'b0;
    wait_edges(2);
    led_m  = 4'b1111;
    mode_m = 2'd0;
    sb.delete();
    n_reset = 1'b1;
    wait_edges(1);
  endtask

  // Clean action press of the given raw width; model predicts the new led.
  task automatic act_press(input int width);
    case (mode_m)
      2'd0: led_m[0] = ~led_m[0];
      2'd1: led_m = led_m + 4'd1;
      2'd2: led_m = {led_m[N-2:0], led_m[N-1]};
      default: led_m = led_m;
    endcase
    push_exp();
    btn_act = 1'b1;
    wait_edges(width);
    btn_act = 1'b0;
    wait_edges(DEB + 8);
  endtask

  task automatic mode_press(input string tag);
    mode_m = mode_m + 2'd1;
    led_m  = entry_of(mode_m);
    btn_mode = 1'b1;
    wait_edges(6);
    btn_mode = 1'b0;
    wait_edges(DEB + 8);
    check({tag, "_mode"}, 32'(mode), 32'(mode_m));
    check({tag, "_led"}, 32'(led), 32'(led_m));
  endtask

  initial begin
    int base;
    led_m  = 4'b1111;
    mode_m = 2'd0;

    // Reset state.
    wait_edges(2);
    check("reset_led", 32'(led), 32'hF);
    check("reset_mode", 32'(mode), 32'd0);
    check("reset_pulse", 32'(act_pulse), 32'd0);
    n_reset = 1'b1;
    wait_edges(1);

    // 1: held action button -> one press, acting at edge E+6.
    base  = pulse_cnt;
    led_m = 4'b1110;
    push_exp();
    btn_act = 1'b1;
    wait_edges(6);
    check("t1_led_e5", 32'(led), 32'hF);
    check("t1_pulse_e5", 32'(act_pulse), 32'd0);
    wait_edges(1);
    check("t1_led_e6", 32'(led), 32'hE);
    check("t1_pulse_e6", 32'(act_pulse), 32'd1);
    wait_edges(13);
    btn_act = 1'b0;
    wait_edges(12);
    check("t1_one_pulse", 32'(pulse_cnt - base), 32'd1);
    check("t1_mode", 32'(mode), 32'd0);

    // 2: short glitch rejected, then a clean 10-cycle press.
    do_reset();
    base = pulse_cnt;
    btn_act = 1'b1;
    wait_edges(3);
    btn_act = 1'b0;
    wait_edges(12);
    check("t2_glitch_pulses", 32'(pulse_cnt - base), 32'd0);
    check("t2_glitch_led", 32'(led), 32'hF);
    act_press(10);
    check("t2_led", 32'(led), 32'hE);

    // 3: COUNT with wrap.
    mode_press("t3_entry");
    check("t3_entry_const", 32'(led), 32'h0);
    for (int i = 0; i < 17; i++) act_press(6);
    check("t3_final_led", 32'(led), 32'h1);
    check("t3_final_mode", 32'(mode), 32'd1);

    // 4: SHIFT rotate with wrap.
    mode_press("t4_entry");
    check("t4_entry_const", 32'(led), 32'h1);
    for (int i = 0; i < 5; i++) act_press(6);
    check("t4_final_led", 32'(led), 32'h2);

    // 5: BLINK run, then a stop press landing on the terminal count.
    mode_press("t5_entry");
    push_exp();                    // run press: led unchanged at P
    btn_act = 1'b1;
    wait_edges(7);                 // edge P
    check("t5_p_led", 32'(led), 32'hF);
    wait_edges(2);
    btn_act = 1'b0;
    wait_edges(5);                 // P+7
    check("t5_p7_led", 32'(led), 32'hF);
    wait_edges(1);                 // P+8
    check("t5_p8_led", 32'(led), 32'h0);
    wait_edges(8);                 // P+16
    check("t5_p16_led", 32'(led), 32'hF);
    wait_edges(8);                 // P+24
    check("t5_p24_led", 32'(led), 32'h0);
    wait_edges(1);                 // P+25
    led_m = 4'b0000;
    push_exp();                    // stop press acts at P+32, inversion suppressed
    btn_act = 1'b1;
    wait_edges(7);                 // P+32
    check("t5_stop_led", 32'(led), 32'h0);
    check("t5_stop_pulse", 32'(act_pulse), 32'd1);
    btn_act = 1'b0;
    wait_edges(20);
    check("t5_frozen_led", 32'(led), 32'h0);
    mode_press("t5_back_toggle");

    // 6: simultaneous presses -> mode wins, no act_pulse.
    base = pulse_cnt;
    mode_m = mode_m + 2'd1;
    led_m  = entry_of(mode_m);
    btn_mode = 1'b1;
    btn_act  = 1'b1;
    wait_edges(6);
    btn_mode = 1'b0;
    btn_act  = 1'b0;
    wait_edges(DEB + 8);
    check("t6_mode", 32'(mode), 32'd1);
    check("t6_led", 32'(led), 32'h0);
    check("t6_no_pulse", 32'(pulse_cnt - base), 32'd0);

    // Reset mid-debounce: immediate return, nothing after release.
    btn_act = 1'b1;
    wait_edges(2);
    n_reset = 1'b0;
    #1;
    check("t6_rst_led", 32'(led), 32'hF);
    check("t6_rst_mode", 32'(mode), 32'd0);
    check("t6_rst_pulse", 32'(act_pulse), 32'd0);
    btn_act = 1'b0;
    wait_edges(2);
    n_reset = 1'b1;
    led_m  = 4'b1111;
    mode_m = 2'd0;
    wait_edges(20);
    check("t6_post_pulses", 32'(pulse_cnt - base), 32'd0);
    check("t6_post_led", 32'(led), 32'hF);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/led_btn_ctrl.md
Name: led_btn_ctrl

Overview:
Parametrised successor to the single-enable LED toggler. Two raw push-buttons are synchronised and debounced, then converted to one-cycle press events. A four-mode state machine drives an N_LED-wide LED bank: toggle, binary count, rotate and free-running blink. It sits between the board button pins and the LED pins in the 1 MHz clock domain.

Parameters:
N_LED, 4, LED bank width; legal range is 2 to 16.
DEB_CYCLES, 20000, number of consecutive cycles a synchronised button must differ from its debounced level before the level is accepted (20 ms at 1 MHz); must be 1 or more.
BLINK_DIV, 250000, cycles between blink inversions in BLINK mode; must be 2 or more.

Ports:
clk  input  1  system clock, 1 MHz nominal, single clock domain.
n_reset  input  1  asynchronous, active-low reset.
btn_mode  input  1  raw mode button, active-high, asynchronous to clk.
btn_act  input  1  raw action button, active-high, asynchronous to clk.
led  output  N_LED  LED drive, registered.
mode  output  2  current mode: 0 = TOGGLE, 1 = COUNT, 2 = SHIFT, 3 = BLINK; registered.
act_pulse  output  1  one-cycle strobe on an accepted action press; registered.

Behaviour:
- Reset (asynchronous, while n_reset = 0): led = all ones; mode = TOGGLE; act_pulse = 0. Synchronisers, debounced levels, debounce counters, blink counter and the blink run flag are all 0.
- Per-button conditioning (each button independent):
  - 2-FF synchroniser produces s.
  - Debounce counter clears whenever s equals the debounced level d. Otherwise it increments.
  - When the counter reaches DEB_CYCLES: d takes the value of s and the counter clears.
  - Press = d rising (d = 1 with its previous-cycle value 0). Press is combinational and lasts one cycle. Releases generate no event.
- Latency for a clean raw 0 to 1 at clk edge E:
  - s = 1 after edge E+1.
  - d = 1 after edge E+1+DEB_CYCLES.
  - The press acts on edge E+2+DEB_CYCLES: led/mode update and act_pulse rise on that edge.
- Glitch rule: a glitch shorter than DEB_CYCLES synchronised cycles produces no event, because the counter clears on return.
- Mode press: mode advances TOGGLE → COUNT → SHIFT → BLINK → TOGGLE. On the same edge, led loads the entry value of the new mode:
  - TOGGLE: all ones.
  - COUNT: all zeros.
  - SHIFT: 1 in bit 0, all other bits 0.
  - BLINK: all ones, run flag = 0, blink counter = 0.
- Action press, by mode:
  - TOGGLE: led[0] inverts; other bits hold.
  - COUNT: led increments by 1 modulo 2^N_LED; all ones wraps to 0.
  - SHIFT: led rotates left by 1; bit N_LED-1 wraps into bit 0.
  - BLINK: run flag inverts. The blink counter clears on the same edge.
- Blink timing:
  - While the run flag is 1, the blink counter counts 0 to BLINK_DIV-1.
  - On the edge where the counter equals BLINK_DIV-1, led inverts all bits and the counter returns to 0.
  - With the run flag at 0, led and the counter hold.
- act_pulse asserts for exactly one cycle for every accepted action press, in any mode. It does not assert when the press is discarded (see next item).
- Simultaneous events:
  - A mode press and an action press on the same cycle: the mode press wins and the action press is discarded.
  - An action press in BLINK on the same cycle the blink counter terminates: the run-flag toggle and counter clear are applied, and that inversion is suppressed.
- Held button: produces exactly one press. A second press requires d to fall (after DEB_CYCLES stable-low cycles) and rise again.
- Reset mid-operation: all state returns to reset values immediately. Any debounce in progress is abandoned. After release, a button already held high is seen as a fresh press once debounced.

Test Plan (use DEB_CYCLES = 4 and BLINK_DIV = 8 for simulation):
1. Reset, then hold btn_act high for 20 cycles. Expect: exactly one act_pulse; led goes 1111 → 1110 at edge E+6; mode = 0.
2. Pulse btn_act high for 3 cycles only (below the debounce threshold). Expect: no act_pulse, led stays 1111. Then a 10-cycle pulse. Expect: led = 1110.
3. One btn_mode press, then 17 btn_act presses. Expect: mode = 1, led = 0000 on entry; after the presses led counts 0001 … 1111 → 0000 → 0001 (wrap checked).
4. Enter SHIFT, then 5 action presses. Expect: led = 0001, 0010, 0100, 1000, 0001, 0010.
5. Enter BLINK, one action press. Expect: led alternates 1111/0000 every 8 cycles. A second press freezes the current value; a mode press returns to TOGGLE with led = 1111.
6. btn_mode and btn_act rise on the same edge with identical widths. Expect: mode advances, led loads the entry value, no act_pulse. Assert n_reset mid-debounce. Expect: led = 1111 and mode = 0 immediately, and no spurious event after release.
